// File: rtl/onehot_index_encoder.sv
// Captures a request vector, then streams the index of each set bit, lowest first,
// one index per accepted valid/ready handshake.
module onehot_index_encoder #(
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [2**IDX_W-1:0]   data_in,
    output logic                  busy,
    output logic [IDX_W-1:0]      data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDX_W:0]        remaining,
    output logic                  dbg_state
);

    localparam int W = 2**IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   pend;
    logic [W-1:0]   pend_cleared;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [W-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Handshake: a transfer happens on an edge where out_valid and out_ready are both 1.
    // out_valid never depends on out_ready, and data holds while out_ready is low.
    assign pend_cleared = pend & (pend - {{(W-1){1'b0}}, 1'b1});

    assign busy      = (state == SCAN);
    assign out_valid = (state == SCAN);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            data_out  <= '0;
            out_last  <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && (data_in != '0)) begin
                        state     <= SCAN;
                        pend      <= data_in;
                        data_out  <= lowest_idx(data_in);
                        remaining <= popcount(data_in);
                        out_last  <= (popcount(data_in) == (IDX_W+1)'(1));
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pend <= pend_cleared;
                        if (out_last) begin
                            state     <= IDLE;
                            data_out  <= '0;
                            out_last  <= 1'b0;
                            remaining <= '0;
                        end else begin
                            // remaining tracks popcount(pend), so the last index is the one at 2->1.
                            data_out  <= lowest_idx(pend_cleared);
                            remaining <= remaining - (IDX_W+1)'(1);
                            out_last  <= (remaining == (IDX_W+1)'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Scoreboard bench: stimulus pushes expected {index, remaining, last} items and a
// negedge monitor compares them against every presented output.
module tb_onehot_index_encoder;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    logic       busy;
    logic [2:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [3:0] remaining;
    logic       dbg_state;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    onehot_index_encoder #(.IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .busy      (busy),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .remaining (remaining),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written items: {index[2:0], remaining[3:0], last}
    task automatic push(input logic [2:0] idx, input logic [3:0] rem, input logic last);
        exp_q.push_back({idx, rem, last});
    endtask

    task automatic load_vec(input logic [7:0] v);
        load    = 1'b1;
        data_in = v;
        tick();
        load    = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (busy && c < 50) begin
            tick();
            c++;
        end
        chk("drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic count_scan(input int expect_cycles);
        int c;
        c = 0;
        while (busy && c < 40) begin
            c++;
            tick();
        end
        chk("scan_cycles", c, expect_cycles);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] dropped;
        if (!reset && n_checks >= 0) begin
            chk("busy_vs_valid", {31'd0, busy}, {31'd0, out_valid});
            got = {data_out, remaining, out_last};
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got idx=%0d rem=%0d last=%0b expected nothing",
                             data_out, remaining, out_last);
                end else begin
                    chk("stream_item", {24'd0, got}, {24'd0, exp_q[0]});
                    if (out_ready) dropped = exp_q.pop_front();
                end
            end else begin
                chk("idle_outputs", {24'd0, got}, 32'd0);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        load      = 1'b1;
        data_in   = 8'hFF;
        out_ready = 1'b1;

        // reset with load asserted: nothing captured
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {24'd0, data_out, remaining, out_valid}, 32'd0);
        tick();
        chk("rst_busy2", {31'd0, busy}, 32'd0);
        chk("rst_outs2", {24'd0, data_out, remaining, out_valid}, 32'd0);
        reset   = 1'b0;
        load    = 1'b0;
        data_in = 8'h00;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // basic stream 1010_0100 -> 2, 5, 7
        push(3'd2, 4'd3, 1'b0);
        push(3'd5, 4'd2, 1'b0);
        push(3'd7, 4'd1, 1'b1);
        load_vec(8'b1010_0100);
        count_scan(3);
        tick();

        // backpressure on 1000_0001
        out_ready = 1'b0;
        push(3'd0, 4'd2, 1'b0);
        push(3'd7, 4'd1, 1'b1);
        load_vec(8'b1000_0001);
        tick();
        tick();
        chk("bp_busy", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        drain();
        tick();

        // zero load is ignored
        load_vec(8'h00);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("zero_busy2", {31'd0, busy}, 32'd0);

        // load during scan (including final handshake) is ignored
        push(3'd4, 4'd2, 1'b0);
        push(3'd5, 4'd1, 1'b1);
        load_vec(8'h30);
        load    = 1'b1;
        data_in = 8'h01;
        tick();
        tick();
        load    = 1'b0;
        data_in = 8'h00;
        chk("overlap_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("overlap_busy2", {31'd0, busy}, 32'd0);

        // full vector
        for (int i = 0; i < 8; i++) push(3'(i), 4'(8 - i), (i == 7));
        load_vec(8'hFF);
        count_scan(8);
        tick();

        // reset mid-scan after index 5 accepted
        push(3'd4, 4'd4, 1'b0);
        push(3'd5, 4'd3, 1'b0);
        load_vec(8'hF0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_outs", {24'd0, data_out, remaining, busy}, 32'd0);
        tick();
        tick();

        push(3'd1, 4'd1, 1'b1);
        load_vec(8'h02);
        count_scan(1);
        tick();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_index_encoder.md
# onehot_index_encoder

Sequential encoder that converts an 8-bit request vector into a stream of 3-bit indices. It captures the vector once, then emits the index of every set bit, lowest first, one per accepted handshake. It is the inverse companion of the 3-to-8 one-hot decoder: a stream of `data_out` indices fed back through that decoder and OR-ed together reconstructs the captured vector. It sits between request/flag-collection logic and any consumer that needs bit numbers instead of a mask.

## Interface
- `IDX_W`, default 3: index width. Vector width is `2**IDX_W`, which is 8 at the default.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture request, sampled only when `busy`=0.
- `data_in` in 8: request vector, sampled together with `load`.
- `busy` out 1: high while a captured vector is being emitted.
- `data_out` out 3: index of the lowest remaining set bit.
- `out_valid` out 1: `data_out` is valid.
- `out_ready` in 1: consumer accepts `data_out` this cycle.
- `out_last` out 1: the current index is the final one of the vector.
- `remaining` out 4: count of set bits still pending, including the current one; range 0..8.

## Operation
- Two states: IDLE and SCAN. `busy` = (state==SCAN). Internal `pend` register is 8 bits.
- **IDLE:**
  - `load`=1 and `data_in`≠0: `pend` <= `data_in`, go to SCAN.
  - `load`=1 and `data_in`=0: ignored; stay IDLE, no output.
- **SCAN:**
  - `data_out` = index of the lowest set bit of `pend`.
  - `out_valid`=1.
  - `out_last`=1 iff `pend` has exactly one bit set.
  - `remaining` = popcount(`pend`).
- **Handshake** (`out_valid` and `out_ready` both 1): clear the lowest set bit of `pend`. If `out_last`=1, go to IDLE.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `data_out`, `out_last` and `remaining` hold stable.
- `load` during SCAN is ignored entirely, including on the final handshake cycle. It does not queue.
- **Outputs in IDLE:** `out_valid`=0, `out_last`=0, `remaining`=0, `data_out`=0.
- All outputs are registered, or decoded only from registered state. There is no combinational path from `out_ready` or `load` to any output.
- `remaining` arithmetic: 4-bit unsigned. It decrements by exactly 1 per handshake and never wraps below 0.
- **Reset values:** state IDLE, `pend`=0, `busy`=0, `out_valid`=0, `out_last`=0, `data_out`=0, `remaining`=0.
- **Reset mid-SCAN:** the vector is discarded. No further indices are emitted and all outputs return to reset values on the next edge.
- **Reset together with `load`:** reset wins; nothing is captured.

## Timing
- `load` accepted at edge N: `busy`, `out_valid` and the first index are visible after edge N, i.e. in cycle N+1. Latency is 1 cycle.
- Throughput is one index per cycle while `out_ready`=1.
- A vector with k set bits and `out_ready` held high occupies SCAN for exactly k cycles. `busy` drops at edge N+k. The next `load` can be accepted in cycle N+k+1.
- **Final handshake at edge M:** in cycle M+1, `out_valid`=0, `busy`=0 and `remaining`=0.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `load`=1 and `data_in`=8'hFF → `busy`=0, `out_valid`=0, `data_out`=0, `remaining`=0 during and after reset; nothing is emitted.
- **Basic stream:** `load`, `data_in`=8'b1010_0100, `out_ready`=1 → `data_out` is 2, 5, 7 on three consecutive cycles. `remaining` is 3, 2, 1. `out_last` is high only with 7. `busy` low on the 4th cycle.
- **Backpressure:** `data_in`=8'b1000_0001, `out_ready`=0 for 3 cycles → `data_out`=0, `remaining`=2, `out_last`=0 held for all 3 cycles. Then with `out_ready`=1 → 0, then 7 with `out_last`=1.
- **Zero and overlapping loads:** `load` with `data_in`=8'h00 → no `out_valid` and `busy` stays 0. `load` of 8'h01 while scanning 8'h30 → stream is 4, 5 only, and 0 never appears.
- **Full vector:** `data_in`=8'hFF → indices 0..7 in order, `remaining` counts 8 down to 1, SCAN lasts exactly 8 cycles.
- **Reset mid-operation:** `data_in`=8'hF0, assert `reset` after index 5 is accepted → `out_valid`=0 next cycle, 6 and 7 are never emitted, and a new `load` of 8'h02 after reset yields index 1.
